// File: rtl/img_buf_pkg.sv
// Shared constants and state encoding for the image frame buffer sequencer
// and the downstream classifier.
package img_buf_pkg;

    localparam int unsigned PIX_NUM = 784;  // 28x28 pixels per frame
    localparam int unsigned AW      = 10;   // RAM address width
    localparam int unsigned DW      = 8;    // pixel width

    typedef enum logic [1:0] {
        WAIT_SOF,
        FILL,
        FULL,
        DRAIN
    } buf_state_t;

endpackage

// File: rtl/img_buf_ctrl.sv
// Fill/drain sequencer for the 784x8 dual-port image RAM. Port A is written
// with one framed pixel stream; port B is streamed out over valid/ready once
// a drain is requested. Fill and drain strictly alternate.
module img_buf_ctrl #(
    parameter int unsigned PIX_NUM = img_buf_pkg::PIX_NUM,
    parameter int unsigned AW      = img_buf_pkg::AW,
    parameter int unsigned DW      = img_buf_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_valid,
    input  logic          pix_sof,
    input  logic [DW-1:0] pix_data,
    output logic          buf_full,
    input  logic          rd_start,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          drop_err,
    output logic          ram_cea,
    output logic [AW-1:0] ram_addra,
    output logic [DW-1:0] ram_dia,
    output logic [AW-1:0] ram_addrb,
    input  logic [DW-1:0] ram_dob
);

    import img_buf_pkg::*;

    localparam logic [AW-1:0] LAST_IDX = AW'(PIX_NUM - 1);

    buf_state_t    state_q, state_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;
    logic          drop_q, drop_d;
    logic          wr_en;
    logic [AW-1:0] addrb;

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_SOF;
            wr_cnt_q <= '0;
            rd_idx_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_idx_q <= rd_idx_d;
            drop_q   <= drop_d;
        end
    end

    // Next-state, counter update, write accept and read address selection
    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_idx_d = rd_idx_q;
        drop_d   = 1'b0;
        wr_en    = 1'b0;
        addrb    = '0;
        case (state_q)
            WAIT_SOF: begin
                if (pix_valid && pix_sof) begin
                    wr_en    = 1'b1;
                    wr_cnt_d = AW'(1);
                    state_d  = FILL;
                end
            end
            FILL: begin
                if (pix_valid) begin
                    wr_en = 1'b1;
                    if (pix_sof) begin
                        // Resync: the partial frame is abandoned and refilled from 0.
                        wr_cnt_d = AW'(1);
                        drop_d   = 1'b1;
                    end else if (wr_cnt_q == LAST_IDX) begin
                        state_d = FULL;
                    end else begin
                        wr_cnt_d = wr_cnt_q + AW'(1);
                    end
                end
            end
            FULL: begin
                drop_d = pix_valid;
                if (rd_start) begin
                    state_d  = DRAIN;
                    rd_idx_d = '0;
                end
            end
            DRAIN: begin
                drop_d = pix_valid;
                if (rd_ready) begin
                    if (rd_idx_q == LAST_IDX) begin
                        // Final beat: park port B on pixel 0 rather than one past the frame.
                        state_d  = WAIT_SOF;
                        rd_idx_d = '0;
                        wr_cnt_d = '0;
                        addrb    = '0;
                    end else begin
                        rd_idx_d = rd_idx_q + AW'(1);
                        addrb    = rd_idx_q + AW'(1);
                    end
                end else begin
                    addrb = rd_idx_q;
                end
            end
            default: begin
                state_d = WAIT_SOF;
            end
        endcase
    end

    assign ram_cea   = wr_en;
    assign ram_addra = pix_sof ? '0 : wr_cnt_q;
    assign ram_dia   = pix_data;
    assign ram_addrb = addrb;

    assign buf_full  = (state_q == FULL);
    assign rd_valid  = (state_q == DRAIN);
    assign rd_data   = ram_dob;
    assign rd_last   = rd_valid && (rd_idx_q == LAST_IDX);
    assign drop_err  = drop_q;

endmodule

// File: tb/tb_img_buf_ctrl.sv
// Scoreboard bench for img_buf_ctrl: drivers push expected RAM writes and
// drained beats into queues; a negedge monitor pops and compares them.
module tb_img_buf_ctrl;

    import img_buf_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pix_valid, pix_sof, rd_start, rd_ready;
    logic [DW-1:0] pix_data;
    logic          buf_full, rd_valid, rd_last, drop_err, ram_cea;
    logic [DW-1:0] rd_data, ram_dia;
    logic [DW-1:0] ram_dob;
    logic [AW-1:0] ram_addra, ram_addrb;

    logic [DW-1:0]      ram [0:1023];
    logic [DW-1:0]      model [PIX_NUM];
    logic [AW+DW-1:0]   wq [$];
    logic [DW:0]        rq [$];

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned drop_seen = 0;
    int unsigned drop_exp = 0;
    logic          stalled = 1'b0;
    logic [DW-1:0] held_data;
    logic          held_last;

    always #5 clk = ~clk;

    img_buf_ctrl #(.PIX_NUM(PIX_NUM), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
        .buf_full(buf_full), .rd_start(rd_start),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .drop_err(drop_err),
        .ram_cea(ram_cea), .ram_addra(ram_addra), .ram_dia(ram_dia),
        .ram_addrb(ram_addrb), .ram_dob(ram_dob)
    );

    // Behavioural dual-port RAM with a 1-cycle registered read
    always @(posedge clk) begin
        if (ram_cea) ram[ram_addra] <= ram_dia;
        ram_dob <= ram[ram_addrb];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pix(input int unsigned seed, input int unsigned i);
        return DW'((i + seed) % 256);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: RAM writes, drained beats, stall stability, drop pulses
    always @(negedge clk) begin
        logic [AW+DW-1:0] we;
        logic [DW:0]      re;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (ram_cea) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", {22'd0, ram_addra}, 32'hFFFF_FFFF);
                end else begin
                    we = wq.pop_front();
                    check("wr_addr", 32'(ram_addra), 32'(we[AW+DW-1:DW]));
                    check("wr_data", 32'(ram_dia), 32'(we[DW-1:0]));
                end
            end
            if (rd_valid && stalled) begin
                check("stall_data", 32'(rd_data), 32'(held_data));
                check("stall_last", 32'(rd_last), 32'(held_last));
            end
            if (rd_valid && rd_ready) begin
                if (rq.size() == 0) begin
                    check("unexpected_beat", 32'(rd_data), 32'hFFFF_FFFF);
                end else begin
                    re = rq.pop_front();
                    check("rd_data", 32'(rd_data), 32'(re[DW:1]));
                    check("rd_last", 32'(rd_last), 32'(re[0]));
                end
            end
            stalled   = rd_valid && !rd_ready;
            held_data = rd_data;
            held_last = rd_last;
            if (drop_err) drop_seen++;
        end
    end

    task automatic send_pixels(input int unsigned seed, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            pix_sof   = (i == 0);
            pix_data  = pix(seed, i);
            wq.push_back({AW'(i), pix(seed, i)});
            model[i] = pix(seed, i);
            if (i == PIX_NUM - 1) check("buf_full_before_last", 32'(buf_full), 32'd0);
            tick();
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        if (n == PIX_NUM) check("buf_full_after_last", 32'(buf_full), 32'd1);
        else              check("buf_full_partial", 32'(buf_full), 32'd0);
        check("write_count", 32'(wq.size()), 32'd0);
    endtask

    task automatic drain(input bit rnd, input int unsigned abort_at, input bit inject);
        int unsigned cyc;
        bit aborted;
        cyc = 0;
        aborted = 1'b0;
        for (int unsigned i = 0; i < PIX_NUM; i++)
            rq.push_back({model[i], (i == PIX_NUM - 1)});
        check("rd_valid_before_start", 32'(rd_valid), 32'd0);
        rd_ready = rnd ? 1'($urandom % 2) : 1'b1;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        check("rd_valid_latency", 32'(rd_valid), 32'd1);
        check("buf_full_in_drain", 32'(buf_full), 32'd0);
        while (rq.size() > 0 && cyc < 5000) begin
            if (abort_at != 0 && (PIX_NUM - rq.size()) >= abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("reset_rd_valid", 32'(rd_valid), 32'd0);
                check("reset_buf_full", 32'(buf_full), 32'd0);
                check("reset_cea", 32'(ram_cea), 32'd0);
                rq.delete();
                aborted = 1'b1;
                break;
            end
            rd_ready  = rnd ? 1'($urandom % 2) : 1'b1;
            pix_valid = inject && cyc >= 10 && cyc < 15;
            pix_sof   = inject && cyc == 12;
            if (pix_valid) drop_exp++;
            tick();
            cyc++;
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        if (!aborted) begin
            check("drain_beats_left", 32'(rq.size()), 32'd0);
            check("rd_valid_after_last", 32'(rd_valid), 32'd0);
            check("buf_full_after_drain", 32'(buf_full), 32'd0);
        end
        rd_ready = 1'b0;
    endtask

    task automatic check_drops(input string name);
        tick();
        tick();
        check(name, drop_seen, drop_exp);
    endtask

    initial begin
        rst_n = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
        rd_start = 1'b0; rd_ready = 1'b0;
        #23;
        check("rst_buf_full", 32'(buf_full), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_drop_err", 32'(drop_err), 32'd0);
        check("rst_cea", 32'(ram_cea), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Idle: non-sof pixels and rd_start are ignored in WAIT_SOF
        for (int i = 0; i < 3; i++) begin
            pix_valid = 1'b1; pix_data = 8'hAA; tick();
        end
        pix_valid = 1'b0;
        rd_start = 1'b1; tick(); rd_start = 1'b0;
        check("idle_rd_valid", 32'(rd_valid), 32'd0);
        check("idle_buf_full", 32'(buf_full), 32'd0);
        check_drops("idle_drops");

        // Full frame, then full-rate drain
        send_pixels(0, PIX_NUM);
        drain(1'b0, 0, 1'b0);

        // Same frame drained with random backpressure
        send_pixels(0, PIX_NUM);
        drain(1'b1, 0, 1'b0);

        // Truncated frame followed by a resync
        send_pixels(50, 100);
        drop_exp++;
        send_pixels(7, PIX_NUM);
        check_drops("resync_drops");
        drain(1'b1, 0, 1'b0);

        // Pixels arriving while FULL and during DRAIN are discarded
        send_pixels(3, PIX_NUM);
        for (int i = 0; i < 3; i++) begin
            pix_valid = 1'b1; pix_sof = (i == 1); pix_data = 8'h55;
            drop_exp++;
            tick();
        end
        pix_valid = 1'b0; pix_sof = 1'b0;
        check("full_held", 32'(buf_full), 32'd1);
        drain(1'b0, 0, 1'b1);
        check_drops("discard_drops");

        // Asynchronous reset mid-drain, then a clean frame
        send_pixels(11, PIX_NUM);
        drain(1'b0, 300, 1'b0);
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick();
        send_pixels(200, PIX_NUM);
        drain(1'b1, 0, 1'b0);
        check_drops("final_drops");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/img_buf_ctrl.md
Name: img_buf_ctrl

Overview:
- Sequencer for the 784x8 dual-port image RAM (one 28x28 8-bit digit frame) in the handwriting-digit path.
- Fill phase: writes one framed pixel stream into RAM port A.
- Drain phase: on request, streams the frame out of port B to the classifier through a valid/ready interface.
- Enforces strict fill/drain alternation, so the RAM never sees a read/write collision.

Parameters:
- PIX_NUM, 784, pixels per frame (28x28).
- AW, 10, RAM address width.
- DW, 8, pixel width.

Ports:
- clk  in  1  single system clock; RAM clka and clkb are tied to it at top level.
- rst_n  in  1  asynchronous active-low reset.
- pix_valid  in  1  input pixel strobe; there is no backpressure on this side.
- pix_sof  in  1  start-of-frame; qualified by pix_valid.
- pix_data  in  DW  input pixel.
- buf_full  out  1  frame complete and awaiting drain.
- rd_start  in  1  request to drain; honoured only while buf_full=1.
- rd_valid  out  1  output pixel valid.
- rd_ready  in  1  consumer ready.
- rd_data  out  DW  output pixel.
- rd_last  out  1  marks pixel PIX_NUM-1.
- drop_err  out  1  1-cycle pulse when an input pixel is discarded or a frame is truncated.
- ram_cea  out  1  port A write enable.
- ram_addra  out  AW  port A address.
- ram_dia  out  DW  port A data.
- ram_addrb  out  AW  port B address.
- ram_dob  in  DW  port B data, 1-cycle registered read (NOREG).

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset values: state=WAIT_SOF, wr_cnt=0, rd_idx=0, buf_full=0, rd_valid=0, drop_err=0, ram_cea=0.
- States: WAIT_SOF, FILL, FULL, DRAIN.
- WAIT_SOF:
  - pix_valid without pix_sof: ignored; no drop_err.
  - pix_valid with pix_sof: write addr 0, wr_cnt<=1, go FILL.
- FILL:
  - pix_valid writes at wr_cnt, then wr_cnt++.
  - pix_valid with pix_sof: resync. Write addr 0, wr_cnt<=1, pulse drop_err (truncated frame).
  - Write at addr PIX_NUM-1: next cycle state=FULL, buf_full=1.
- Write path is combinational:
  - ram_cea = accepted pix_valid.
  - ram_addra = pix_sof ? 0 : wr_cnt.
  - ram_dia = pix_data.
  - ram_cea=0 in FULL and DRAIN.
- FULL/DRAIN:
  - Any pix_valid is discarded and pulses drop_err the next cycle.
  - A pix_sof arriving in these states is also discarded.
- FULL:
  - rd_start: next cycle state=DRAIN, buf_full=0, rd_valid=1, rd_idx=0.
  - ram_addrb=0 throughout FULL, so ram_dob already holds pixel 0.
- DRAIN:
  - rd_data = ram_dob, passed combinationally.
  - ram_addrb = (rd_valid & rd_ready) ? rd_idx+1 : rd_idx, combinational.
  - Stalled: the RAM re-reads the same address, so rd_data stays stable.
  - rd_ready held high gives 1 pixel/cycle.
  - rd_last = rd_valid & (rd_idx==PIX_NUM-1).
  - Handshake on the last pixel: rd_valid=0 next cycle, rd_idx=0, wr_cnt=0, state=WAIT_SOF.
- Latency:
  - rd_start to first rd_valid: 1 cycle.
  - Last input write to buf_full: 1 cycle.
- rd_start outside FULL: ignored.
- rd_valid, once high, stays high until handshake (AXI-style stability rule).
- Counters never exceed PIX_NUM-1; no wrap occurs inside a state.
- Reset mid-operation: immediate return to reset values. RAM contents are don't-care; the next frame fully overwrites them.

Decomposition:
- Package img_buf_pkg: PIX_NUM, AW, DW localparams and the state enum (WAIT_SOF, FILL, FULL, DRAIN). Shared with the downstream classifier, which needs PIX_NUM and DW.
- No sub-module: a single FSM plus two counters.
- The RAM instance lives in the parent, next to this block.

Test Plan:
- Reset, then 784 pixels (value = addr[7:0]) with sof on the first -> buf_full=1 exactly 1 cycle after the 784th write; ram_cea pulsed 784 times at addresses 0..783.
- rd_start with rd_ready=1 -> rd_valid 1 cycle later; 784 consecutive beats with data 0x00,0x01,...,0x0F (addr 783 -> 0x0F); rd_last only on beat 784; state returns to WAIT_SOF.
- Random rd_ready toggling (about 50%) during drain -> rd_data stable while stalled; sequence is identical to the previous test with no skips or duplicates.
- 100 pixels, then sof plus 784 pixels -> one drop_err pulse at the resync; drained frame equals the second stream only.
- pix_valid asserted during FULL and DRAIN -> one drop_err pulse per pixel, ram_cea=0, drained data unchanged.
- rst_n asserted asynchronously mid-drain (beat 300) -> rd_valid and buf_full drop immediately; a new full frame after reset drains correctly from pixel 0.
